// File: rtl/serial_pattern_gen_if.sv
// Request/stream bundle between a pattern requester (master) and serial_pattern_gen (slave).
// The master supplies start/abort and the capture data; the slave returns the serial bit and status.
interface serial_pattern_gen_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic             out;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern, repeat_n,
    input  out, busy, done
  );

  modport slave (
    input  start, abort, pattern, repeat_n,
    output out, busy, done
  );
endinterface

// File: rtl/serial_pattern_gen.sv
// Moore serial pattern generator: captures a pattern and repeat count on start, then shifts
// the pattern out MSB-first repeat_n times back-to-back and pulses done once.
module serial_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_pattern_gen_if.slave  bus
);
  localparam int BC_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] pat_q,   pat_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] rep_q,   rep_d;

  // NOTE: every register is assigned with <= so all flops update from pre-edge values together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      pat_q     <= '0;
      bit_cnt_q <= '0;
      rep_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      pat_q     <= pat_d;
      bit_cnt_q <= bit_cnt_d;
      rep_q     <= rep_d;
    end
  end

  // NOTE: each _d signal takes its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    pat_d     = pat_q;
    bit_cnt_d = bit_cnt_q;
    rep_d     = rep_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          shift_d   = bus.pattern;
          pat_d     = bus.pattern;
          rep_d     = bus.repeat_n;
          bit_cnt_d = BIT_LAST;
          state_d   = (bus.repeat_n != '0) ? S_SHIFT : S_DONE;
        end
      end

      S_SHIFT: begin
        // Abort takes priority over the end-of-transfer condition.
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bit_cnt_q == '0) begin
          if (rep_q > REP_ONE) begin
            shift_d   = pat_q;
            bit_cnt_d = BIT_LAST;
            rep_d     = rep_q - REP_ONE;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode registered state only, so reset forces them low without a clock edge.
  assign bus.busy = (state_q == S_SHIFT);
  assign bus.out  = (state_q == S_SHIFT) && shift_q[WIDTH-1];
  assign bus.done = (state_q == S_DONE);

endmodule

// File: doc/serial_pattern_gen.md
Name: serial_pattern_gen

Overview:
- Moore-style serial pattern generator that drives the single-bit `in` stream consumed by our Moore sequence detector (`des`).
- Captures a parallel pattern and a repeat count on `start`, then shifts the pattern out MSB-first, one bit per clock, the requested number of times, and pulses `done`.
- Sits in front of the detector in the datapath and in benches, replacing hand-written `in` stimulus.

Parameters:
- WIDTH, 8, pattern length in bits (>=2).
- CNT_W, 4, width of repeat count; max repeats = 2**CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- start  input  1  request; sampled only in IDLE.
- abort  input  1  synchronous cancel; honoured in SHIFT only.
- pattern  input  WIDTH  bits to send, MSB first; captured on accepted start.
- repeat_n  input  CNT_W  number of back-to-back pattern repetitions; captured on accepted start.
- out  output  1  serial bit; connects to the detector `in`.
- busy  output  1  high while bits are being shifted.
- done  output  1  one-cycle pulse after the last bit of the last repetition.

Behaviour:
- Reset (asynchronous):
  - state=IDLE; out=0, busy=0, done=0.
  - Shift register, pattern copy, bit counter and repeat counter all cleared.
  - Applies mid-operation with no completion pulse.
- Outputs are pure functions of registered state (Moore); no combinational path from any input to any output.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - out=0, busy=0, done=0.
  - start=1 at edge k: latch pattern into the shift register and a pattern copy, latch repeat_n into the repeat counter, set bit counter=WIDTH-1.
  - repeat_n!=0: next state SHIFT.
  - repeat_n==0: next state DONE; no bits sent.
- SHIFT:
  - busy=1; out=shift register MSB.
  - First bit (pattern[WIDTH-1]) is visible after edge k, i.e. latency 1 cycle from the start sample.
  - Each edge: shift left by 1, decrement bit counter.
  - At bit counter==0 with repeat counter>1: reload shift register from the pattern copy, bit counter=WIDTH-1, decrement repeat counter. No gap between repetitions.
  - At bit counter==0 with repeat counter==1: next state DONE.
  - Total SHIFT cycles = WIDTH*repeat_n exactly.
- DONE:
  - done=1, busy=0, out=0 for exactly one cycle; then IDLE.
- start while SHIFT or DONE: ignored, not queued. New start accepted in IDLE the cycle after DONE at the earliest.
- abort=1 in SHIFT: next state IDLE, out=0, busy=0, no done pulse. abort ignored in IDLE and DONE.
- abort and the last-bit condition in the same cycle: abort wins (IDLE, no done).
- Changes to pattern or repeat_n after capture do not affect the transfer in progress.
- Counters never wrap: bit counter only in WIDTH-1..0, repeat counter only decrements while >1.

Test Plan:
- Reset at t=0 for 4 ns, then release: out=0, busy=0, done=0. Assert reset mid-SHIFT at a non-edge time: outputs go to 0 immediately, without waiting for clk.
- pattern=8'b1011_0010, repeat_n=1, start one cycle: out = 1,0,1,1,0,0,1,0 on 8 consecutive cycles starting the cycle after start. busy high for exactly 8 cycles. done high for 1 cycle immediately after.
- pattern=8'hA5, repeat_n=3: 24 contiguous bits = A5A5A5 MSB-first, no idle bit between repetitions. busy=24 cycles, then a single done pulse.
- repeat_n=0 with start: busy never asserts, out stays 0, done pulses on the cycle after start, then IDLE.
- start re-asserted during SHIFT and changed pattern mid-transfer: the transfer in progress is unaffected and the second start is not queued. abort on bit 4 of 8: IDLE next cycle, out=0, no done.
- Feed a generated pattern into the detector (`des`): the detector `out` matches the golden model for the same bit sequence that was previously hand-driven on `in`.
